// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with edge/level sources, mask, vector and ack handshake.
// Optional software interrupt source enabled by defining IRQ_CTRL_SWI_EN.
module irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [7:0]  EDGE_MASK = 8'h00
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [1:0]      AD,
    input  logic [7:0]      DI,
    output logic [7:0]      DO,
    input  logic            rw,
    input  logic            cs,
    input  logic [NSRC-1:0] src,
    output logic            intr
);

`ifdef IRQ_CTRL_SWI_EN
    localparam int         NT      = NSRC + 1;
    localparam logic [7:0] SWI_BIT = 8'(9'd1 << NSRC);
`else
    localparam int         NT      = NSRC;
    localparam logic [7:0] SWI_BIT = 8'h00;
`endif
    localparam logic [7:0] VALID     = 8'((9'd1 << NT) - 9'd1);
    localparam logic [7:0] EDGE_BITS = (EDGE_MASK | SWI_BIT) & VALID;

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  isr_id, isr_nxt;
    logic [7:0]  pend, mask, src_q;
    logic        gie, cs_q;

    logic [7:0]  src_x, active, pend_set, pend_clr, pend_nxt, swi_set;
    logic [2:0]  win;
    logic        any, wr, rd_first, ack;

    assign src_x    = 8'(src);
    assign wr       = cs & ~rw;
    assign rd_first = cs & rw & ~cs_q & (AD == 2'd2);
    assign ack      = wr & (AD == 2'd2) & (state == SERVICE);
    assign active   = pend & mask;
    assign any      = |active;

    always_comb begin
        win = '0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) win = 3'(i);
        end
    end

    // Edge sources: a fresh rise beats a simultaneous clear; level sources just follow src.
    assign swi_set  = (wr && AD == 2'd3 && DI[2]) ? SWI_BIT : 8'h00;
    assign pend_set = EDGE_BITS & ((src_x & ~src_q) | swi_set);
    assign pend_clr = EDGE_BITS & (((wr && AD == 2'd0) ? DI : 8'h00) |
                                   (ack ? (8'd1 << isr_id) : 8'h00));
    assign pend_nxt = (~EDGE_BITS & src_x & VALID) |
                      (EDGE_BITS & (pend_set | (pend & ~pend_clr)));

    always_comb begin
        state_nxt = state;
        isr_nxt   = isr_id;
        case (state)
            IDLE: begin
                if (rd_first && any) begin
                    isr_nxt   = win;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            isr_id <= '0;
        end else begin
            state  <= state_nxt;
            isr_id <= isr_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend  <= '0;
            mask  <= '0;
            gie   <= 1'b0;
            intr  <= 1'b0;
            src_q <= '0;
            cs_q  <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            src_q <= src_x;
            cs_q  <= cs;
            intr  <= gie & any & (state == IDLE);
            if (wr && AD == 2'd1) mask <= DI & VALID;
            if (wr && AD == 2'd3) gie  <= DI[0];
        end
    end

    always_comb begin
        DO = 8'h00;
        case (AD)
            2'd0: DO = pend;
            2'd1: DO = mask;
            2'd2: DO = any ? {1'b1, 4'b0000, win} : 8'h00;
            2'd3: DO = {6'b0, (state == SERVICE), gie};
            default: DO = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios plus random traffic against a rule-level model.
module tb_irq_ctrl;
`ifdef IRQ_CTRL_SWI_EN
    localparam int         NSRC = 7;
    localparam bit         SWI  = 1'b1;
`else
    localparam int         NSRC = 8;
    localparam bit         SWI  = 1'b0;
`endif
    localparam logic [7:0] EMASK = 8'h31;

    logic            CLK = 1'b0;
    logic            RESET, rw, cs, intr;
    logic [1:0]      AD;
    logic [7:0]      DI, DO;
    logic [NSRC-1:0] src;

    irq_ctrl #(.NSRC(NSRC), .EDGE_MASK(EMASK)) dut (
        .CLK(CLK), .RESET(RESET), .AD(AD), .DI(DI), .DO(DO),
        .rw(rw), .cs(cs), .src(src), .intr(intr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      nm;
        bit         is_intr;
        logic [7:0] exp;
    } chk_t;
    chk_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit [7:0] cur_src = '0;

    // Reference model state: what software would see.
    bit [7:0] m_pend, m_mask, m_srcq;
    bit       m_gie, m_svc, m_intr, m_csq;
    int       m_isr;

    function automatic bit is_edge(int i);
        return (i == NSRC) ? 1'b1 : EMASK[i];
    endfunction

    function automatic int m_win();
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_mask[i]) return i;
        return 0;
    endfunction

    function automatic bit m_any();
        return (m_pend & m_mask) != 0;
    endfunction

    function automatic logic [7:0] m_do(bit [1:0] a);
        case (a)
            2'd0:    return m_pend;
            2'd1:    return m_mask;
            2'd2:    return m_any() ? 8'h80 + 8'(m_win()) : 8'h00;
            default: return {6'b0, m_svc, m_gie};
        endcase
    endfunction

    task automatic model_edge(bit r, bit c, bit rwv, bit [1:0] a, bit [7:0] d, bit [7:0] s);
        bit       wr, rdf, any, ack, rise, clr, set;
        int       win, nt;
        bit [7:0] np;
        if (r) begin
            m_pend = 0; m_mask = 0; m_srcq = 0; m_gie = 0;
            m_svc = 0; m_intr = 0; m_csq = 0; m_isr = 0;
            return;
        end
        nt  = NSRC + (SWI ? 1 : 0);
        wr  = c && !rwv;
        rdf = c && rwv && !m_csq && a == 2;
        any = m_any();
        win = m_win();
        ack = wr && a == 2 && m_svc;
        np  = 0;
        for (int i = 0; i < nt; i++) begin
            clr = (wr && a == 0 && d[i]) || (ack && m_isr == i);
            if (i == NSRC) begin
                set   = wr && a == 3 && d[2];
                np[i] = set ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end else if (is_edge(i)) begin
                rise  = s[i] && !m_srcq[i];
                np[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end else begin
                np[i] = s[i];
            end
        end
        m_intr = m_gie && any && !m_svc;
        if (!m_svc && rdf && any) begin
            m_isr = win;
            m_svc = 1;
        end else if (ack) begin
            m_svc = 0;
        end
        if (wr && a == 1) m_mask = d & 8'((9'd1 << nt) - 9'd1);
        if (wr && a == 3) m_gie = d[0];
        m_pend = np;
        m_srcq = s & 8'((9'd1 << NSRC) - 9'd1);
        m_csq  = c;
    endtask

    task automatic step(bit r, bit c, bit rwv, bit [1:0] a, bit [7:0] d, string nm);
        RESET = r; cs = c; rw = rwv; AD = a; DI = d;
        src = cur_src[NSRC-1:0];
        #1;
        if (chk_en) begin
            q.push_back('{nm, 1'b0, m_do(a)});
            q.push_back('{nm, 1'b1, {7'b0, m_intr}});
        end
        model_edge(r, c, rwv, a, d, cur_src);
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(bit [1:0] a, string nm);  step(0, 1, 1, a, 8'h00, nm); endtask
    task automatic wrt(bit [1:0] a, bit [7:0] d, string nm); step(0, 1, 0, a, d, nm); endtask
    task automatic idle(string nm);             step(0, 0, 1, 2'd0, 8'h00, nm); endtask

    initial begin
        forever begin
            @(negedge CLK);
            while (q.size() > 0) begin
                chk_t       e;
                logic [7:0] act;
                e   = q.pop_front();
                act = e.is_intr ? {7'b0, intr} : DO;
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s %s: got %h expected %h at %0t",
                             e.nm, e.is_intr ? "intr" : "DO", act, e.exp, $time);
                end
            end
        end
    end

    initial begin
        step(1, 0, 1, 2'd0, 8'h00, "reset");
        chk_en = 1'b1;
        rd(0, "reset_pend"); rd(1, "reset_mask"); idle("reset_idle");
        rd(2, "reset_vec");  rd(3, "reset_ctrl");

        wrt(1, 8'h01, "edge_setup"); wrt(3, 8'h01, "edge_setup");
        cur_src[0] = 1'b1; idle("edge_pulse");
        cur_src[0] = 1'b0; idle("edge_pend"); idle("edge_intr"); rd(0, "edge_pend_rd");
        idle("edge_pre_vec"); rd(2, "edge_vec"); idle("edge_svc"); rd(3, "edge_ctrl_svc");
        idle("edge_svc"); wrt(2, 8'h00, "edge_ack"); idle("edge_after_ack");
        rd(0, "edge_pend_clr"); rd(3, "edge_ctrl_idle");

        wrt(1, 8'h0C, "level_mask"); cur_src[3:2] = 2'b11;
        idle("level_pend"); idle("level_intr"); rd(2, "level_vec82");
        idle("level_svc"); wrt(2, 8'h00, "level_ack1"); idle("level_reassert");
        idle("level_idle"); rd(2, "level_vec82b");
        cur_src[2] = 1'b0; idle("level_drop2"); wrt(2, 8'h00, "level_ack2");
        idle("level_idle2"); rd(2, "level_vec83"); idle("level_svc3");
        wrt(2, 8'h00, "level_ack3"); cur_src[3:2] = 2'b00; idle("level_clear");

        wrt(1, 8'h01, "setwin_mask"); idle("setwin_idle");
        cur_src[0] = 1'b1; wrt(0, 8'h01, "setwin_wr");
        cur_src[0] = 1'b0; idle("setwin_after"); rd(0, "setwin_pend");
        idle("held_pre"); rd(2, "held_vec1"); rd(2, "held_vec2"); rd(2, "held_vec3");
        idle("held_svc"); wrt(2, 8'h00, "held_ack"); idle("held_idle");
        wrt(2, 8'h00, "idle_ack"); rd(3, "idle_ack_ctrl"); rd(0, "idle_ack_pend");

        wrt(3, 8'h00, "gie_off"); cur_src[0] = 1'b1; idle("gie_pulse");
        cur_src[0] = 1'b0; idle("gie_nointr"); idle("gie_nointr2");
        rd(2, "gie_vec80"); idle("gie_svc"); rd(3, "gie_ctrl_svc");
        step(1, 0, 1, 2'd0, 8'h00, "reset_svc"); rd(3, "reset_svc_ctrl"); rd(0, "reset_svc_pend");

`ifdef IRQ_CTRL_SWI_EN
        wrt(1, 8'h80, "swi_mask"); wrt(3, 8'h01, "swi_gie"); wrt(3, 8'h05, "swi_set");
        idle("swi_pend"); rd(0, "swi_pend_rd"); idle("swi_intr"); rd(3, "swi_ctrl");
        idle("swi_pre_vec"); rd(2, "swi_vec87"); idle("swi_svc");
        wrt(2, 8'h00, "swi_ack"); idle("swi_after"); rd(0, "swi_pend_clr");
`endif

        for (int k = 0; k < 3000; k++) begin
            bit       r, c, rwv;
            bit [1:0] a;
            bit [7:0] d;
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 2) != 0);
            rwv = $urandom_range(0, 1);
            a   = 2'($urandom_range(0, 3));
            d   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) cur_src = 8'($urandom);
            step(r, c, rwv, a, d, "random");
        end

        idle("drain"); idle("drain");
        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
